// File: rtl/vga_fb_writer.sv
// rtl/vga_fb_writer.sv - buffered pixel-write front end and clear engine for the RGB332 framebuffer
//
// Purpose: accepts 32-bit byte-enabled CPU writes (four RGB332 pixels) into a
// small word FIFO. Each word is drained as single-pixel writes on the
// framebuffer BRAM write port. A clear engine fills the whole frame with one
// colour after any queued words have drained.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   bus_req/addr/data/be      CPU write request, held until bus_ack
//   bus_ack                   one-cycle pulse when the word enters the FIFO
//   clr_start, clr_color      clear request pulse and its colour
//   busy                      clear pending or running
//   oob_err                   sticky: an out-of-range word was dropped
//   fb_we, fb_addr, fb_din    framebuffer write port (all registered)

module vga_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_PIXELS  = 480000,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_data,
  input  logic [3:0]        bus_be,
  output logic              bus_ack,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              busy,
  output logic              oob_err,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_din
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WA = ADDR_W - 2;
  localparam int EW = WA + 36;
  // One extra bit so a limit equal to 2**WA words is still representable.
  localparam logic [WA:0]     WORD_END = (WA + 1)'(FB_PIXELS / 4);
  localparam logic [ADDR_W:0] PIX_END  = (ADDR_W + 1)'(FB_PIXELS);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [WA-1:0]     word_q, word_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        color_q, color_d;
  logic              busy_q, busy_d;
  logic              oob_q, oob_d;
  logic              bus_ack_q, bus_ack_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_din_q, fb_din_d;

  logic              fifo_full, fifo_empty, push, pop;
  logic [EW-1:0]     head;
  logic [WA-1:0]     head_word, src_word;
  logic [31:0]       head_data, src_data;
  logic [3:0]        head_be, src_mask;
  logic [1:0]        lane;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    low_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) low_lane = 2'(i);
    end
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // The registered ack blocks acceptance, so one request is never taken twice.
  assign push = bus_req && !fifo_full && !bus_ack_q && !busy_q;

  assign head = mem_q[rd_ptr_q[PW-1:0]];
  assign {head_word, head_data, head_be} = head;

  // In IDLE the first lane is issued straight from the FIFO head so the first
  // write is visible the cycle after the pop; WRITE continues from the latch.
  assign src_word = (state_q == IDLE) ? head_word : word_q;
  assign src_data = (state_q == IDLE) ? head_data : data_q;
  assign src_mask = (state_q == IDLE) ? head_be   : mask_q;
  assign lane     = low_lane(src_mask);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    data_d    = data_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    busy_d    = busy_q;
    oob_d     = oob_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_din_d  = fb_din_q;
    pop       = 1'b0;
    bus_ack_d = push;
    wr_ptr_d  = wr_ptr_q + (PW + 1)'(push);

    if (clr_start && !busy_q) begin
      busy_d  = 1'b1;
      color_d = clr_color;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if ({1'b0, head_word} >= WORD_END) begin
            oob_d = 1'b1;
          end else if (head_be != 4'd0) begin
            word_d    = head_word;
            data_d    = head_data;
            fb_we_d   = 1'b1;
            fb_addr_d = {src_word, lane};
            fb_din_d  = src_data[{lane, 3'b000} +: 8];
            mask_d    = src_mask & ~(4'b0001 << lane);
            state_d   = WRITE;
          end
        end else if (busy_q) begin
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
          fb_din_d  = color_q;
          cnt_d     = (ADDR_W + 1)'(1);
          state_d   = CLEAR;
        end
      end
      WRITE: begin
        // The cycle with an empty mask is the bubble while the last lane shows.
        if (mask_q != 4'd0) begin
          fb_we_d   = 1'b1;
          fb_addr_d = {src_word, lane};
          fb_din_d  = src_data[{lane, 3'b000} +: 8];
          mask_d    = src_mask & ~(4'b0001 << lane);
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == PIX_END) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = cnt_q[ADDR_W-1:0];
          fb_din_d  = color_q;
          cnt_d     = cnt_q + (ADDR_W + 1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {bus_addr[ADDR_W-1:2], bus_data, bus_be};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      word_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      oob_q     <= 1'b0;
      bus_ack_q <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      word_q    <= word_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      busy_q    <= busy_d;
      oob_q     <= oob_d;
      bus_ack_q <= bus_ack_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_din_q  <= fb_din_d;
    end
  end

  assign bus_ack = bus_ack_q;
  assign busy    = busy_q;
  assign oob_err = oob_q;
  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_din  = fb_din_q;

endmodule
